// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
//   Shared types and constants for the serial ADC capture front end.
//
//   adc_state_e      : conversion FSM states
//   FRAME_BITS       : SCLK periods per conversion frame
//   LEAD_ZEROS       : zero bits the ADC sends ahead of the result
//   ADC_BITS         : converter resolution
//   sample_div_legal : minimum sample period that fits one complete frame
//                      (lead, 16 SCLK periods, done, quiet time)
// -----------------------------------------------------------------------------
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        DONE,
        QUIET
    } adc_state_e;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int ADC_BITS   = 12;

    // One frame occupies CLK_DIV (lead) + 32*CLK_DIV (shift) + 1 (done)
    // + CLK_DIV (quiet) cycles; the extra margin keeps a tick from landing
    // on the cycle the FSM returns to IDLE.
    function automatic bit sample_div_legal(input int clk_div, input int sample_div);
        return sample_div >= (34 * clk_div + 2);
    endfunction

endpackage

// File: rtl/adc_spi_rx_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running sample-rate pacer. Counts 0..DIV-1 and wraps; tick_o is high
//   for exactly the one cycle in which the count equals DIV-1. Kept as its own
//   block so output-side stages (DAC pacing) can reuse the same divider.
//
//   Ports
//     clk    : system clock
//     rst    : asynchronous reset, active low
//     tick_o : one-cycle pulse every DIV clk cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 2268
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int          CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours, independent of the order
    // the simulator evaluates processes in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/adc_spi_rx.sv
// -----------------------------------------------------------------------------
// adc_spi_rx
//   Capture stage for an AD7476-class serial ADC (16-clock frame, 4 leading
//   zeros, 12-bit result, MSB first). A fixed-rate tick starts one conversion;
//   the frame is deserialised and the top DATA_WIDTH bits of the result are
//   presented with a one-cycle valid strobe.
//
//   Parameters
//     DATA_WIDTH   : output sample width, 1..12 (top bits of the result)
//     CLK_DIV      : SCLK half-period in clk cycles (>= 1)
//     SAMPLE_DIV   : clk cycles per conversion
//     CHECK_PARAMS : 1 = refuse to elaborate when SAMPLE_DIV is too short
//                    to fit a frame; 0 lets a deliberately short period
//                    through (overrun behaviour is then well defined)
//
//   Ports
//     clk       : system clock
//     rst       : asynchronous reset, active low
//     en        : 1 = start conversions on ticks; 0 = ignore new ticks
//     sdata_i   : ADC serial data, launched on SCLK falling edges
//     sclk_o    : SPI clock, idles high
//     cs_n_o    : ADC chip select, active low
//     data_o    : latest sample, unsigned offset binary, held between strobes
//     vld_o     : one-cycle strobe, data_o is new in this cycle
//     overrun_o : sticky, a tick arrived while a frame was still running
// -----------------------------------------------------------------------------
module adc_spi_rx
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_DIV   = 2268,
    parameter bit CHECK_PARAMS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sdata_i,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  vld_o,
    output logic                  overrun_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (DATA_WIDTH < 1 || DATA_WIDTH > ADC_BITS) begin : g_bad_data_width
        $error("adc_spi_rx: DATA_WIDTH must be 1..%0d", ADC_BITS);
    end

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("adc_spi_rx: CLK_DIV must be >= 1");
    end

    if (CHECK_PARAMS && !sample_div_legal(CLK_DIV, SAMPLE_DIV)) begin : g_bad_sample_div
        $error("adc_spi_rx: SAMPLE_DIV too small for CLK_DIV");
    end

    // -------------------------------------------------------------------------
    // Sample-rate tick
    // -------------------------------------------------------------------------
    logic tick;

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // -------------------------------------------------------------------------
    // Frame sequencer
    // -------------------------------------------------------------------------
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    adc_state_e          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;     // cycles spent in the current phase
    logic [3:0]          bit_q, bit_d;     // SCLK period index within the frame
    logic                high_q, high_d;   // 1 = in the SCLK high half-period
    // Only the low ADC_BITS of the frame are kept: the leading zeros are
    // shifted in first and fall off the top by the end of the frame.
    logic [ADC_BITS-1:0] shift_q, shift_d;
    logic                div_last;

    assign div_last = (div_q == DIV_LAST);

    // NOTE: every signal written here gets a default at the top of the block,
    // so no path through the case statement can leave one unassigned and
    // infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        high_d  = high_q;
        shift_d = shift_q;

        unique case (state_q)
            IDLE: begin
                // Ticks with en low are simply dropped; no pending start.
                if (tick && en) begin
                    state_d = LEAD;
                    div_d   = '0;
                end
            end

            LEAD: begin
                if (div_last) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    high_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!high_q) begin
                        // SCLK rises on this edge: the ADC launched the bit
                        // on the preceding falling edge, so it is settled.
                        high_d  = 1'b1;
                        shift_d = {shift_q[ADC_BITS-2:0], sdata_i};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        high_d = 1'b0;
                        bit_d  = bit_q + 4'd1;
                    end
                end
            end

            DONE: begin
                state_d = QUIET;
                div_d   = '0;
            end

            QUIET: begin
                if (div_last) begin
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state so
    // each pin changes on the same edge as the FSM that drives it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            high_q    <= 1'b1;
            shift_q   <= '0;
            sclk_o    <= 1'b1;
            cs_n_o    <= 1'b1;
            data_o    <= '0;
            vld_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            high_q  <= high_d;
            shift_q <= shift_d;

            cs_n_o <= !(state_d == LEAD || state_d == SHIFT);
            sclk_o <= !(state_d == SHIFT && !high_d);
            vld_o  <= (state_d == DONE);

            if (state_d == DONE) begin
                data_o <= shift_d[ADC_BITS-1 -: DATA_WIDTH];
            end

            // A tick outside IDLE cannot be honoured; the running frame is
            // left alone and the loss is only recorded.
            if (tick && state_q != IDLE) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_rx
//   Three instances share clock, reset and enable:
//     u_a : defaults (8-bit, CLK_DIV 4, SAMPLE_DIV 2268) - main scenarios
//     u_b : 12-bit output width
//     u_c : SAMPLE_DIV 100, too short for a frame, to provoke overrun
//   Each instance has its own behavioural ADC that drives frame bits MSB
//   first on SCLK falling edges. The cycle counter pc restarts at reset, so
//   tick k of every instance sits at cycle (k+1)*SAMPLE_DIV-1.
// -----------------------------------------------------------------------------
module tb_adc_spi_rx;

    localparam int SD   = 2268;
    localparam int SD_C = 100;

    logic        clk;
    logic        rst;
    logic        en;

    logic        sdata_a, sclk_a, cs_n_a, vld_a, ovr_a;
    logic [7:0]  data_a;
    logic        sdata_b, sclk_b, cs_n_b, vld_b, ovr_b;
    logic [11:0] data_b;
    logic        sdata_c, sclk_c, cs_n_c, vld_c, ovr_c;
    logic [7:0]  data_c;

    logic [15:0] word_a = 16'h0ABC;
    logic [15:0] word_b = 16'h0801;
    logic [15:0] word_c = 16'h0ABC;
    logic [3:0]  idx_a  = 4'd15;
    logic [3:0]  idx_b  = 4'd15;
    logic [3:0]  idx_c  = 4'd15;

    int checks   = 0;
    int failures = 0;
    int pc       = 0;

    // Monitor counters for instance a (monotonic; tasks take differences)
    int   vld_cnt_a   = 0;
    int   rise_cnt_a  = 0;
    int   cs_low_a    = 0;
    int   vld_cnt_b   = 0;
    logic prev_sclk_a = 1'b1;
    logic prev_vld_a  = 1'b0;
    logic dbl_vld_a   = 1'b0;

    adc_spi_rx u_a (
        .clk(clk), .rst(rst), .en(en), .sdata_i(sdata_a),
        .sclk_o(sclk_a), .cs_n_o(cs_n_a), .data_o(data_a),
        .vld_o(vld_a), .overrun_o(ovr_a)
    );

    adc_spi_rx #(.DATA_WIDTH(12)) u_b (
        .clk(clk), .rst(rst), .en(en), .sdata_i(sdata_b),
        .sclk_o(sclk_b), .cs_n_o(cs_n_b), .data_o(data_b),
        .vld_o(vld_b), .overrun_o(ovr_b)
    );

    adc_spi_rx #(.SAMPLE_DIV(SD_C), .CHECK_PARAMS(1'b0)) u_c (
        .clk(clk), .rst(rst), .en(en), .sdata_i(sdata_c),
        .sclk_o(sclk_c), .cs_n_o(cs_n_c), .data_o(data_c),
        .vld_o(vld_c), .overrun_o(ovr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 0;
        else      pc <= pc + 1;
    end

    // ADC models: chip-select fall re-arms the bit index, each SCLK fall
    // launches the next bit.
    always @(negedge sclk_a or negedge cs_n_a) begin
        if (sclk_a) idx_a <= 4'd15;
        else begin sdata_a <= word_a[idx_a]; idx_a <= idx_a - 4'd1; end
    end
    always @(negedge sclk_b or negedge cs_n_b) begin
        if (sclk_b) idx_b <= 4'd15;
        else begin sdata_b <= word_b[idx_b]; idx_b <= idx_b - 4'd1; end
    end
    always @(negedge sclk_c or negedge cs_n_c) begin
        if (sclk_c) idx_c <= 4'd15;
        else begin sdata_c <= word_c[idx_c]; idx_c <= idx_c - 4'd1; end
    end

    always @(negedge clk) begin
        prev_sclk_a <= sclk_a;
        prev_vld_a  <= vld_a;
        if (!cs_n_a && sclk_a && !prev_sclk_a) rise_cnt_a <= rise_cnt_a + 1;
        if (!cs_n_a)                           cs_low_a   <= cs_low_a + 1;
        if (vld_a)                             vld_cnt_a  <= vld_cnt_a + 1;
        if (vld_a && prev_vld_a)               dbl_vld_a  <= 1'b1;
        if (vld_b)                             vld_cnt_b  <= vld_cnt_b + 1;
    end

    function automatic int tick_at(input int k);
        return (k + 1) * SD - 1;
    endfunction

    task automatic wait_to(input int target);
        while (pc < target) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sclk_a !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%0h exp=1", sclk_a); end
        checks++; if (cs_n_a !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%0h exp=1", cs_n_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", data_a); end
        checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0h exp=0", vld_a); end
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0h exp=0", ovr_a); end
        rst = 1'b1;
    endtask

    task automatic test_overrun;
        wait_to(SD_C - 1);
        checks++; if (cs_n_c !== 1'b1) begin failures++; $display("FAIL ovr_cs_at_tick got=%0h exp=1", cs_n_c); end
        wait_to(SD_C);
        checks++; if (cs_n_c !== 1'b0) begin failures++; $display("FAIL ovr_cs_after_tick got=%0h exp=0", cs_n_c); end
        wait_to(2 * SD_C - 1);
        checks++; if (ovr_c !== 1'b0) begin failures++; $display("FAIL ovr_before_2nd_tick got=%0h exp=0", ovr_c); end
        wait_to(2 * SD_C);
        checks++; if (ovr_c !== 1'b1) begin failures++; $display("FAIL ovr_after_2nd_tick got=%0h exp=1", ovr_c); end
        wait_to(SD_C - 1 + 133);
        checks++; if (vld_c !== 1'b1) begin failures++; $display("FAIL ovr_frame_vld got=%0h exp=1", vld_c); end
        checks++; if (data_c !== 8'hAB) begin failures++; $display("FAIL ovr_frame_data got=%0h exp=ab", data_c); end
        wait_to(SD_C - 1 + 140);
        checks++; if (ovr_c !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0h exp=1", ovr_c); end
    endtask

    task automatic test_first_frame;
        int v0, r0, c0;
        v0 = vld_cnt_a; r0 = rise_cnt_a; c0 = cs_low_a;
        wait_to(tick_at(0));
        checks++; if (cs_n_a !== 1'b1) begin failures++; $display("FAIL first_cs_at_tick got=%0h exp=1", cs_n_a); end
        wait_to(tick_at(0) + 1);
        checks++; if (cs_n_a !== 1'b0) begin failures++; $display("FAIL first_cs_latency got=%0h exp=0", cs_n_a); end
        wait_to(tick_at(0) + 133);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL first_vld got=%0h exp=1", vld_a); end
        checks++; if (data_a !== 8'hAB) begin failures++; $display("FAIL first_data got=%0h exp=ab", data_a); end
        checks++; if (cs_n_a !== 1'b1) begin failures++; $display("FAIL first_cs_at_vld got=%0h exp=1", cs_n_a); end
        @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL first_vld_one_cycle got=%0h exp=0", vld_a); end
        checks++; if (vld_cnt_a - v0 != 1) begin failures++; $display("FAIL first_vld_count got=%0d exp=1", vld_cnt_a - v0); end
        checks++; if (rise_cnt_a - r0 != 16) begin failures++; $display("FAIL first_sclk_rises got=%0d exp=16", rise_cnt_a - r0); end
        checks++; if (cs_low_a - c0 != 132) begin failures++; $display("FAIL first_cs_low_cycles got=%0d exp=132", cs_low_a - c0); end
    endtask

    task automatic test_width12;
        checks++; if (vld_cnt_b != 1) begin failures++; $display("FAIL w12_vld_count got=%0d exp=1", vld_cnt_b); end
        checks++; if (data_b !== 12'h801) begin failures++; $display("FAIL w12_data got=%0h exp=801", data_b); end
    endtask

    task automatic test_back_to_back;
        int v0;
        word_a = 16'h0FFF;
        v0 = vld_cnt_a;
        wait_to(tick_at(1));
        checks++; if (data_a !== 8'hAB) begin failures++; $display("FAIL b2b_data_held got=%0h exp=ab", data_a); end
        wait_to(tick_at(1) + 133);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL b2b_vld1 got=%0h exp=1", vld_a); end
        checks++; if (data_a !== 8'hFF) begin failures++; $display("FAIL b2b_data1 got=%0h exp=ff", data_a); end
        @(negedge clk);
        checks++; if (vld_cnt_a - v0 != 1) begin failures++; $display("FAIL b2b_spacing1 got=%0d exp=1", vld_cnt_a - v0); end
        word_a = 16'h0000;
        v0 = vld_cnt_a;
        wait_to(tick_at(2) + 133);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL b2b_vld2 got=%0h exp=1", vld_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL b2b_data2 got=%0h exp=0", data_a); end
        @(negedge clk);
        checks++; if (vld_cnt_a - v0 != 1) begin failures++; $display("FAIL b2b_spacing2 got=%0d exp=1", vld_cnt_a - v0); end
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0h exp=0", ovr_a); end
    endtask

    task automatic test_en_drop;
        int v0, c0;
        word_a = 16'h0C30;
        v0 = vld_cnt_a;
        wait_to(tick_at(3) + 40);
        en = 1'b0;
        wait_to(tick_at(3) + 133);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL en_drop_vld got=%0h exp=1", vld_a); end
        checks++; if (data_a !== 8'hC3) begin failures++; $display("FAIL en_drop_data got=%0h exp=c3", data_a); end
        wait_to(tick_at(3) + 150);
        checks++; if (vld_cnt_a - v0 != 1) begin failures++; $display("FAIL en_drop_vld_count got=%0d exp=1", vld_cnt_a - v0); end
        v0 = vld_cnt_a; c0 = cs_low_a;
        wait_to(tick_at(4) + 200);
        checks++; if (cs_low_a != c0) begin failures++; $display("FAIL en_off_cs_activity got=%0d exp=%0d", cs_low_a, c0); end
        checks++; if (vld_cnt_a != v0) begin failures++; $display("FAIL en_off_vld got=%0d exp=%0d", vld_cnt_a, v0); end
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL en_off_overrun got=%0h exp=0", ovr_a); end
        en = 1'b1;
        word_a = 16'h0999;
        wait_to(tick_at(5));
        checks++; if (cs_low_a != c0) begin failures++; $display("FAIL en_on_no_early_start got=%0d exp=%0d", cs_low_a, c0); end
        wait_to(tick_at(5) + 1);
        checks++; if (cs_n_a !== 1'b0) begin failures++; $display("FAIL en_on_cs_at_tick got=%0h exp=0", cs_n_a); end
        wait_to(tick_at(5) + 133);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL en_on_vld got=%0h exp=1", vld_a); end
        checks++; if (data_a !== 8'h99) begin failures++; $display("FAIL en_on_data got=%0h exp=99", data_a); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        wait_to(tick_at(6) + 60);
        checks++; if (cs_n_a !== 1'b0) begin failures++; $display("FAIL midrst_in_frame got=%0h exp=0", cs_n_a); end
        rst = 1'b0;
        #1;
        checks++; if (cs_n_a !== 1'b1) begin failures++; $display("FAIL midrst_cs_n got=%0h exp=1", cs_n_a); end
        checks++; if (sclk_a !== 1'b1) begin failures++; $display("FAIL midrst_sclk got=%0h exp=1", sclk_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL midrst_data got=%0h exp=0", data_a); end
        checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL midrst_vld got=%0h exp=0", vld_a); end
        v0 = vld_cnt_a;
        word_a = 16'h0555;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        wait_to(tick_at(0));
        checks++; if (cs_n_a !== 1'b1) begin failures++; $display("FAIL midrst_idle_until_tick got=%0h exp=1", cs_n_a); end
        wait_to(tick_at(0) + 133);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL midrst_next_vld got=%0h exp=1", vld_a); end
        checks++; if (data_a !== 8'h55) begin failures++; $display("FAIL midrst_next_data got=%0h exp=55", data_a); end
        @(negedge clk);
        checks++; if (vld_cnt_a - v0 != 1) begin failures++; $display("FAIL midrst_vld_count got=%0d exp=1", vld_cnt_a - v0); end
        checks++; if (dbl_vld_a !== 1'b0) begin failures++; $display("FAIL vld_never_double got=%0h exp=0", dbl_vld_a); end
    endtask

    initial begin
        test_reset();
        test_overrun();
        test_first_frame();
        test_width12();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_spi_rx.md
Name: adc_spi_rx

Overview:
Upstream capture stage of the effect chain. Paces conversions of a serial 12-bit ADC (AD7476-class: 16-clock frame, 4 leading zeros, MSB first) at a fixed sample rate. Deserialises each frame and presents one DATA_WIDTH-bit sample per conversion on a data/valid pair that feeds the effect stages (wah, etc.) directly.

Parameters:
DATA_WIDTH, 8, output sample width; legal 1..12; the top DATA_WIDTH bits of the 12-bit result are used.
CLK_DIV, 4, SCLK half-period in clk cycles; SCLK = clk/(2*CLK_DIV); legal >= 1.
SAMPLE_DIV, 2268, clk cycles per sample tick (100 MHz / 2268 ≈ 44.1 kHz); legal >= 34*CLK_DIV + 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
en  input  1  1 = conversions run; 0 = new ticks are ignored and any in-flight frame completes.
sdata_i  input  1  ADC serial data; launched by the ADC on SCLK falling edges.
sclk_o  output  1  SPI clock; idles high.
cs_n_o  output  1  ADC chip select, active low.
data_o  output  DATA_WIDTH  latest sample, unsigned offset binary.
vld_o  output  1  one-cycle strobe; data_o is new in this cycle.
overrun_o  output  1  sticky flag: a tick arrived while a frame was in progress.

Behaviour:
- Reset (rst=0, async): sclk_o=1, cs_n_o=1, data_o=0, vld_o=0, overrun_o=0, tick counter=0, state=IDLE. A reset mid-frame aborts the frame immediately; no vld_o is issued.
- Tick counter: free-runs 0..SAMPLE_DIV-1 regardless of en. tick=1 in the cycle the count equals SAMPLE_DIV-1. The counter wraps to 0 on the next cycle.
- All outputs are registered.
- FSM states:
  - IDLE: cs_n=1, sclk=1. If tick and en -> LEAD. If tick and !en, stay in IDLE.
  - LEAD: cs_n=0, sclk=1, held for CLK_DIV cycles (CS setup), then -> SHIFT.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
    - sdata_i is shifted into a 16-bit register (MSB first) on the clk edge where sclk_o goes 0->1.
    - After the 16th high phase -> DONE.
  - DONE: one cycle. cs_n=1, sclk=1, vld_o=1, data_o=frame[11 -: DATA_WIDTH]. frame[15:12] is ignored (no check is made). -> QUIET.
  - QUIET: cs_n=1 for CLK_DIV cycles (ADC quiet time), then -> IDLE.
- Latency: tick in cycle T gives cs_n_o low at T+1 and vld_o high at T+33*CLK_DIV+1 (T+133 at default). cs_n_o returns high in the same cycle as vld_o.
- Overrun: a tick while state != IDLE (including DONE and QUIET) is dropped and sets overrun_o. overrun_o clears only on reset. The frame in progress is unaffected.
- en deasserted mid-frame: the frame finishes, vld_o fires, then the FSM stays in IDLE.
- en asserted: the first conversion starts at the next tick, not immediately.
- data_o holds its value between strobes. vld_o is never high for two consecutive cycles.

Decomposition:
- adc_pkg:
  - state enum (IDLE, LEAD, SHIFT, DONE, QUIET);
  - localparams FRAME_BITS=16, LEAD_ZEROS=4, ADC_BITS=12;
  - the SAMPLE_DIV legality expression, used for an elaboration-time assertion.
- Sub-module: tick_gen (parameter DIV; ports clk, rst, tick_o) holds the sample-rate counter, so later stages can reuse it for the output DAC pacing.

Test Plan:
- Reset release, en=1, ADC model returns 0x0ABC -> first vld_o at cycle 133 after the first tick; data_o=0xAB; exactly 16 sclk_o rising edges while cs_n_o=0; cs_n_o low for 132 cycles.
- Continuous run, samples 0x0FFF then 0x0000 -> successive vld_o strobes exactly 2268 cycles apart; data_o=0xFF then 0x00; overrun_o stays 0.
- DATA_WIDTH=12, ADC returns 0x0801 -> data_o=0x801.
- SAMPLE_DIV=100 with CLK_DIV=4 (override the legality assertion in the bench) -> overrun_o=1 after the second tick; the first frame's data is still delivered correctly.
- en dropped 40 cycles after a tick -> the current frame completes with one vld_o; no further cs_n_o activity; re-asserting en resumes conversion at the next tick.
- rst pulsed low during SHIFT (cycle T+60) -> outputs return to reset values in that cycle; no vld_o; a normal frame follows the first tick after release.
